// File: rtl/apa102_frame_driver.sv
//----------------------------------------------------------------------------
// Module   : apa102_frame_driver
// Brief    : Double-buffered APA102 strand driver (start frame, LED words, end frame)
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module apa102_frame_driver #(
  parameter  int NUM_LEDS = 12,
  parameter  int SCK_HALF = 64,
  localparam int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_bright,
  input  logic [7:0]    wr_blue,
  input  logic [7:0]    wr_green,
  input  logic [7:0]    wr_red,
  input  logic          start,
  input  logic          auto_refresh,
  output logic          busy,
  output logic          done,
  output logic          sck,
  output logic          mosi
);

  localparam int END_WORDS  = (NUM_LEDS + 63) / 64;
  localparam int TOTAL_BITS = 32 * (1 + NUM_LEDS + END_WORDS);
  localparam int HW         = $clog2(2 * SCK_HALF);
  localparam int BW         = $clog2(TOTAL_BITS);

  localparam logic [31:0]   LED_OFF      = 32'hE000_0000;
  localparam logic [HW-1:0] HALF_LAST    = HW'(SCK_HALF - 1);
  localparam logic [HW-1:0] PERIOD_LAST  = HW'(2 * SCK_HALF - 1);
  localparam logic [BW-1:0] START_LAST   = BW'(31);
  localparam logic [BW-1:0] LED_LAST_BIT = BW'(32 * (1 + NUM_LEDS) - 1);
  localparam logic [BW-1:0] FRAME_LAST   = BW'(TOTAL_BITS - 1);
  localparam logic [BW-1:0] LED_BASE     = BW'(32);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    START_FRAME = 2'd1,
    LED         = 2'd2,
    END_FRAME   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q,  half_d;
  logic [BW-1:0] bit_q,   bit_d;
  logic          sck_q,   sck_d;
  logic          mosi_q,  mosi_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic [31:0]   shadow_q [NUM_LEDS];
  logic [31:0]   active_q [NUM_LEDS];

  logic          w_accept;
  logic [31:0]   w_wr_word;
  logic [BW-1:0] w_led_off;
  logic [AW-1:0] w_led_idx;

  assign w_accept  = (state_q == IDLE) && (start || auto_refresh);
  assign w_wr_word = {3'b111, wr_bright, wr_blue, wr_green, wr_red};

  // Snapshot reads shadow_q before this edge's write lands, so a same-edge
  // write shows up only in the following frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow_q[i] <= LED_OFF;
        active_q[i] <= LED_OFF;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          shadow_q[i] <= w_wr_word;
        end
        if (w_accept) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        busy_d = 1'b0;
        if (start || auto_refresh) begin
          state_d = START_FRAME;
          half_d  = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        half_d = half_q + 1'b1;
        if (half_q == HALF_LAST) begin
          sck_d = 1'b1;
        end
        if (half_q == PERIOD_LAST) begin
          half_d = '0;
          sck_d  = 1'b0;
          bit_d  = bit_q + 1'b1;
          if ((state_q == START_FRAME) && (bit_q == START_LAST)) begin
            state_d = LED;
          end else if ((state_q == LED) && (bit_q == LED_LAST_BIT)) begin
            state_d = END_FRAME;
          end else if ((state_q == END_FRAME) && (bit_q == FRAME_LAST)) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // mosi always reflects the bit at the next position; it only differs from
  // the current value when a new bit begins.
  always_comb begin
    w_led_off = bit_d - LED_BASE;
    w_led_idx = AW'(w_led_off[BW-1:5]);
    mosi_d    = 1'b0;
    unique case (state_d)
      LED:       mosi_d = active_q[w_led_idx][~w_led_off[4:0]];
      END_FRAME: mosi_d = 1'b1;
      default:   mosi_d = 1'b0;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_apa102_frame_driver.sv
//----------------------------------------------------------------------------
// Module   : tb_apa102_frame_driver
// Brief    : Randomized self-checking bench with a frame-level reference model
// Revision : 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_apa102_frame_driver;

  localparam int          NA    = 2;
  localparam int          HA    = 2;
  localparam int          NB    = 3;
  localparam int          HB    = 1;
  localparam logic [31:0] OFF   = 32'hE000_0000;
  localparam int          CYC_A = 32 * (1 + NA + 1) * 2 * HA;
  localparam int          CYC_B = 32 * (1 + NB + 1) * 2 * HB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n   = 1'b0;
  logic [4:0] wr_bright = '0;
  logic [7:0] wr_blue   = '0;
  logic [7:0] wr_green  = '0;
  logic [7:0] wr_red    = '0;
  logic       wr_en_a   = 1'b0;
  logic [0:0] wr_addr_a = '0;
  logic       start_a   = 1'b0;
  logic       auto_a    = 1'b0;
  logic       wr_en_b   = 1'b0;
  logic [1:0] wr_addr_b = '0;
  logic       start_b   = 1'b0;
  logic       auto_b    = 1'b0;
  logic       busy_a, done_a, sck_a, mosi_a;
  logic       busy_b, done_b, sck_b, mosi_b;
  logic       sel = 1'b0;

  wire obs_busy = sel ? busy_b : busy_a;
  wire obs_done = sel ? done_b : done_a;
  wire obs_sck  = sel ? sck_b  : sck_a;
  wire obs_mosi = sel ? mosi_b : mosi_a;

  apa102_frame_driver #(.NUM_LEDS(NA), .SCK_HALF(HA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_bright(wr_bright), .wr_blue(wr_blue), .wr_green(wr_green), .wr_red(wr_red),
    .start(start_a), .auto_refresh(auto_a),
    .busy(busy_a), .done(done_a), .sck(sck_a), .mosi(mosi_a)
  );

  apa102_frame_driver #(.NUM_LEDS(NB), .SCK_HALF(HB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_bright(wr_bright), .wr_blue(wr_blue), .wr_green(wr_green), .wr_red(wr_red),
    .start(start_b), .auto_refresh(auto_b),
    .busy(busy_b), .done(done_b), .sck(sck_b), .mosi(mosi_b)
  );

  // Reference model: what each strand should hold, and the frame it implies.
  logic [31:0] shadow_a [NA];
  logic [31:0] shadow_b [NB];
  logic [31:0] exp_words [$];
  logic [31:0] cap_words [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) shadow_a[i] = OFF;
    for (int i = 0; i < NB; i++) shadow_b[i] = OFF;
  endfunction

  function automatic void build_expected(input bit which);
    exp_words.delete();
    exp_words.push_back(32'h0000_0000);
    if (which) for (int i = 0; i < NB; i++) exp_words.push_back(shadow_b[i]);
    else       for (int i = 0; i < NA; i++) exp_words.push_back(shadow_a[i]);
    exp_words.push_back(32'hFFFF_FFFF);
  endfunction

  task automatic set_pixel(input logic [4:0] br, input logic [7:0] b, input logic [7:0] g,
                           input logic [7:0] r);
    wr_bright = br; wr_blue = b; wr_green = g; wr_red = r;
  endtask

  task automatic write_a(input int addr, input logic [4:0] br, input logic [7:0] b,
                         input logic [7:0] g, input logic [7:0] r);
    set_pixel(br, b, g, r);
    wr_addr_a = 1'(addr);
    wr_en_a   = 1'b1;
    @(negedge clk);
    wr_en_a = 1'b0;
    if (addr < NA) shadow_a[addr] = {3'b111, br, b, g, r};
  endtask

  task automatic write_b(input int addr, input logic [4:0] br, input logic [7:0] b,
                         input logic [7:0] g, input logic [7:0] r);
    set_pixel(br, b, g, r);
    wr_addr_b = 2'(addr);
    wr_en_b   = 1'b1;
    @(negedge clk);
    wr_en_b = 1'b0;
    if (addr < NB) shadow_b[addr] = {3'b111, br, b, g, r};
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  // Entered on the negedge just after the accepting edge; returns on the done cycle.
  task automatic observe_frame(input string tag, input int exp_cycles, input int exp_half);
    logic        prev;
    logic [31:0] w;
    int          nb, cycles, first_rise, early_done;
    cap_words.delete();
    prev = 1'b0; w = '0; nb = 0; cycles = 0; first_rise = -1; early_done = 0;
    check_eq({tag, "_busy0"}, 32'(obs_busy), 32'd1);
    check_eq({tag, "_sck0"},  32'(obs_sck),  32'd0);
    check_eq({tag, "_mosi0"}, 32'(obs_mosi), 32'd0);
    while (obs_busy && cycles < 4000) begin
      if (obs_sck && !prev) begin
        w = {w[30:0], obs_mosi};
        nb++;
        if (nb % 32 == 0) cap_words.push_back(w);
        if (first_rise < 0) first_rise = cycles;
      end
      if (obs_done) early_done++;
      prev = obs_sck;
      cycles++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 32'(cycles), 32'(exp_cycles));
    check_eq({tag, "_first_rise"}, 32'(first_rise), 32'(exp_half));
    check_eq({tag, "_done_while_busy"}, 32'(early_done), 32'd0);
    check_eq({tag, "_done"}, 32'(obs_done), 32'd1);
    check_eq({tag, "_sck_end"}, 32'(obs_sck), 32'd0);
    check_eq({tag, "_mosi_end"}, 32'(obs_mosi), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, "_nwords"}, 32'(cap_words.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i),
               (i < cap_words.size()) ? cap_words[i] : 32'hxxxx_xxxx, exp_words[i]);
  endtask

  task automatic check_done_drop(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(obs_done), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish after %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbusy, ndone, lows, cyc, last;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy_a", 32'(busy_a), 32'd0);
    check_eq("rst_done_a", 32'(done_a), 32'd0);
    check_eq("rst_sck_a",  32'(sck_a),  32'd0);
    check_eq("rst_mosi_a", 32'(mosi_a), 32'd0);
    check_eq("rst_busy_b", 32'(busy_b), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_sck_a", 32'(sck_a), 32'd0);

    // Default frame after reset: all LEDs off
    build_expected(0);
    pulse_start_a();
    observe_frame("dflt", CYC_A, HA);
    check_frame("dflt");
    check_done_drop("dflt");

    // Known pixel values
    write_a(0, 5'd31, 8'hFF, 8'h00, 8'h80);
    write_a(1, 5'd1,  8'h00, 8'hFF, 8'h00);
    build_expected(0);
    pulse_start_a();
    observe_frame("known", CYC_A, HA);
    check_frame("known");
    check_eq("known_led0_lit", cap_words.size() > 1 ? cap_words[1] : 32'hx, 32'hFFFF_0080);
    check_eq("known_led1_lit", cap_words.size() > 2 ? cap_words[2] : 32'hx, 32'hE100_FF00);
    check_done_drop("known");

    // Randomized writes then frames
    for (int it = 0; it < 3; it++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++)
        write_a($urandom_range(0, NA - 1), 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      build_expected(0);
      pulse_start_a();
      observe_frame($sformatf("rnd%0d", it), CYC_A, HA);
      check_frame($sformatf("rnd%0d", it));
      check_done_drop($sformatf("rnd%0d", it));
    end

    // Start and write while busy: current frame unchanged, no queued frame
    build_expected(0);
    pulse_start_a();
    fork
      observe_frame("midw", CYC_A, HA);
      begin
        repeat (100) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        write_a(0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
    join
    check_frame("midw");
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a) nbusy++;
    end
    check_eq("midw_no_queued_frame", 32'(nbusy), 32'd0);
    build_expected(0);
    pulse_start_a();
    observe_frame("midw_next", CYC_A, HA);
    check_frame("midw_next");
    check_done_drop("midw_next");

    // Auto refresh: three back-to-back frames
    auto_a = 1'b1;
    ndone = 0; lows = 0; cyc = 0; last = 0;
    while (ndone < 3 && cyc < 3 * 530) begin
      @(negedge clk);
      cyc++;
      if (done_a) begin
        ndone++;
        if (ndone > 1) check_eq($sformatf("auto_gap%0d", ndone - 1), 32'(cyc - last), 32'd513);
        last = cyc;
        if (ndone == 3) auto_a = 1'b0;
      end
      if (!busy_a && (ndone == 1 || ndone == 2)) lows++;
    end
    check_eq("auto_done_count", 32'(ndone), 32'd3);
    check_eq("auto_idle_cycles", 32'(lows), 32'd2);
    @(negedge clk);
    check_eq("auto_stopped", 32'(busy_a), 32'd0);

    // Reset mid-frame
    pulse_start_a();
    repeat (200) @(negedge clk);
    check_eq("rstmid_busy_before", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("rstmid_busy", 32'(busy_a), 32'd0);
    check_eq("rstmid_sck",  32'(sck_a),  32'd0);
    check_eq("rstmid_mosi", 32'(mosi_a), 32'd0);
    check_eq("rstmid_done", 32'(done_a), 32'd0);
    model_reset();
    build_expected(0);
    reset_n = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    observe_frame("postrst", CYC_A, HA);
    check_frame("postrst");
    check_done_drop("postrst");

    // Out-of-range address on a 3-LED strand is ignored
    sel = 1'b1;
    write_b(3, 5'd31, 8'h12, 8'h34, 8'h56);
    build_expected(1);
    pulse_start_b();
    observe_frame("oor", CYC_B, HB);
    check_frame("oor");
    check_done_drop("oor");

    // Highest valid address on the 3-LED strand
    write_b(2, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    build_expected(1);
    pulse_start_b();
    observe_frame("last_led", CYC_B, HB);
    check_frame("last_led");
    check_done_drop("last_led");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
